mul_tree_bf16: RTL
==================

MUL_TREE_BF16 -- requirements
Module: mul_tree_bf16

Interface
REQ-001 SHALL have parameter NUM_IN, default 8, number of bf16 operand lanes; power of two, 2..16.
REQ-002 SHALL have parameter MUL_LAT, default 3, pipeline stages per multiplier level; 1..4.
REQ-003 SHALL have parameter TAG_W, default 8, width of the sideband tag carried with each product.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_ops  input  16*NUM_IN  bf16 operands; lane k at bits [16k+15:16k].
REQ-007 SHALL have port in_cnt  input  $clog2(NUM_IN)+1  active operand count; lanes 0..in_cnt-1 used.
REQ-008 SHALL have port in_tag  input  TAG_W  sideband tag travelling with the transaction.
REQ-009 SHALL have port in_valid  input  1  transaction offered.
REQ-010 SHALL have port in_ready  output  1  transaction accepted when in_valid && in_ready.
REQ-011 SHALL have port out_prod  output  16  bf16 product of active lanes.
REQ-012 SHALL have port out_tag  output  TAG_W  tag of the transaction in out_prod.
REQ-013 SHALL have port out_flags  output  3  {nan, inf, zero} status of out_prod.
REQ-014 SHALL have port out_valid  output  1  result present.
REQ-015 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.

Function
REQ-016 SHALL pad lanes with index >= in_cnt with bf16 1.0 (0x3F80) before the first level.
REQ-017 SHALL treat in_cnt == 0 as all lanes padded (result 0x3F80); in_cnt > NUM_IN SHALL saturate to NUM_IN.
REQ-018 SHALL reduce in a balanced binary tree of log2(NUM_IN) levels: NUM_IN/2, NUM_IN/4, ..., 1 multipliers.
REQ-019 SHALL have latency L = log2(NUM_IN)*MUL_LAT cycles from acceptance to out_valid when never stalled.
REQ-020 SHALL accept one transaction per cycle while out_ready is high (full throughput).
REQ-021 SHALL drive in_ready = !(out_valid && !out_ready); a stall freezes every stage, valid bit and tag.
REQ-022 SHALL hold out_prod, out_tag, out_flags stable while out_valid && !out_ready.
REQ-023 SHALL pipeline per-stage valid bits and tags alongside data; empty stages (bubbles) never raise out_valid.
REQ-024 Multiply SHALL be bf16: sign XOR, exponent add minus bias 127, 8x8 mantissa product with hidden bit, one-bit normalisation.
REQ-025 SHALL round to nearest, ties to even, on the 7-bit mantissa.
REQ-026 SHALL flush subnormal inputs and subnormal results to signed zero.
REQ-027 SHALL produce signed infinity (exp 0xFF, mant 0) on exponent overflow, including overflow caused by rounding.
REQ-028 SHALL output canonical NaN 0x7FC0 if any operand is NaN or for 0 x inf.
REQ-029 out_flags SHALL be derived from out_prod: nan = exp 0xFF & mant!=0; inf = exp 0xFF & mant==0; zero = exp 0 .
REQ-030 Tag SHALL emerge unchanged with its own product; ordering SHALL be strictly FIFO.

Reset
REQ-031 On rst all stage valid bits, out_valid SHALL be 0; out_prod, out_tag, out_flags SHALL be 0; in_ready SHALL be 1 in the cycle after rst deasserts.
REQ-032 rst asserted mid-operation SHALL discard all in-flight transactions; none appear on the output after reset.
REQ-033 in_valid during rst SHALL not be accepted.

Structure
REQ-034 bf16 constants (ONE 0x3F80, QNAN 0x7FC0, BIAS 127) and flag bit indices SHALL live in the shared package bf16_pkg.
REQ-035 One sub-module bf16_mul_pipe SHALL implement a single MUL_LAT-stage multiplier with enable (stall) input; the tree SHALL instantiate it via generate.
REQ-036 Valid/tag pipeline SHALL be in the top level, length L, sharing the same enable.

Verification
REQ-037 NUM_IN=8, MUL_LAT=3, in_cnt=2, ops 0x4000,0x4040, tag 0x11 -> out_prod 0x40C0 (6.0), tag 0x11, flags 000, 9 cycles after acceptance.
REQ-038 in_cnt=3, ops 0x4000,0x4040,0x3FC0 -> out_prod 0x4110 (9.0); in_cnt=0 -> 0x3F80.
REQ-039 ops 0x7F00,0x4000 -> 0x7F80, flags 010; ops 0x0000,0x7F80 -> 0x7FC0, flags 100; subnormal 0x0001 x 0x3F80 -> 0x0000, flags 001.
REQ-040 20 back-to-back transactions, out_ready toggled randomly -> all 20 outputs in order, none lost or duplicated, outputs stable while stalled, in_ready low only while stalled.
REQ-041 rst asserted for one cycle with 5 transactions in flight -> out_valid 0 afterwards until new input; first new result correct after L cycles.
REQ-042 Repeat REQ-037 with NUM_IN=2,16 and MUL_LAT=1,4 -> latencies 1,4*4=16 etc. equal log2(NUM_IN)*MUL_LAT.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared bf16 definitions for the multiplier tree.
//   ONE / QNAN / BIAS  : bf16 constants (1.0, canonical quiet NaN, exponent bias)
//   FLAG_*             : bit positions of {nan, inf, zero} in the status flags
//   cls_e, mul_raw_t   : operand class and unrounded product carried between
//                        the multiply and round stages
//   flags_of()         : status flags of a packed bf16 value
package bf16_pkg;

  localparam logic [15:0] ONE  = 16'h3F80;
  localparam logic [15:0] QNAN = 16'h7FC0;
  localparam int          BIAS = 127;

  localparam int FLAG_NAN  = 2;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_ZERO = 0;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } cls_e;

  typedef struct packed {
    cls_e               cls;
    logic               sgn;
    logic signed [9:0]  exp;   // unbiased sum, re-biased once: ea + eb - BIAS
    logic [15:0]        mant;  // 1.7 x 1.7 significand product, range [2^14, 2^16)
  } mul_raw_t;

  function automatic logic [2:0] flags_of(input logic [15:0] v);
    logic [2:0] f;
    f            = '0;
    f[FLAG_NAN]  = (v[14:7] == 8'hFF) && (v[6:0] != 7'h00);
    f[FLAG_INF]  = (v[14:7] == 8'hFF) && (v[6:0] == 7'h00);
    f[FLAG_ZERO] = (v[14:7] == 8'h00);
    return f;
  endfunction

endpackage

// File: rtl/mul_tree_bf16_if.sv
// Handshake bundle of the bf16 multiplier tree.
//   in_ops/in_cnt/in_tag/in_valid -> in_ready : operand transaction
//   out_prod/out_tag/out_flags/out_valid <- out_ready : result transaction
//   master : producer of operands / consumer of results
//   slave  : the multiplier tree
interface mul_tree_bf16_if #(
  parameter int NUM_IN = 8,
  parameter int TAG_W  = 8
);
  localparam int CNT_W = $clog2(NUM_IN) + 1;

  logic [16*NUM_IN-1:0] in_ops;
  logic [CNT_W-1:0]     in_cnt;
  logic [TAG_W-1:0]     in_tag;
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          out_prod;
  logic [TAG_W-1:0]     out_tag;
  logic [2:0]           out_flags;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_ops, in_cnt, in_tag, in_valid, out_ready,
    input  in_ready, out_prod, out_tag, out_flags, out_valid
  );

  modport slave (
    input  in_ops, in_cnt, in_tag, in_valid, out_ready,
    output in_ready, out_prod, out_tag, out_flags, out_valid
  );
endinterface

// File: rtl/bf16_mul_pipe.sv
// One bf16 multiplier, MUL_LAT register stages, frozen while en is low.
//   clk : clock
//   en  : advance enable (low = stall, every stage holds)
//   a,b : bf16 operands
//   p   : bf16 product, MUL_LAT cycles after the operands
// Subnormals flush to signed zero, round to nearest even, overflow to
// signed infinity, NaN / 0 x inf give the canonical quiet NaN.
module bf16_mul_pipe
  import bf16_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        en,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p
);

  localparam int RN = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  function automatic mul_raw_t mul_unpack(input logic [15:0] x, input logic [15:0] y);
    mul_raw_t r;
    logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    x_zero = (x[14:7] == 8'h00);
    y_zero = (y[14:7] == 8'h00);
    x_inf  = (x[14:7] == 8'hFF) && (x[6:0] == 7'h00);
    y_inf  = (y[14:7] == 8'hFF) && (y[6:0] == 7'h00);
    x_nan  = (x[14:7] == 8'hFF) && (x[6:0] != 7'h00);
    y_nan  = (y[14:7] == 8'hFF) && (y[6:0] != 7'h00);
    r.sgn  = x[15] ^ y[15];
    r.exp  = $signed(10'(x[14:7])) + $signed(10'(y[14:7])) - $signed(10'(BIAS));
    r.mant = 16'({1'b1, x[6:0]}) * 16'({1'b1, y[6:0]});
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
      r.cls = CLS_NAN;
    end else if (x_inf || y_inf) begin
      r.cls = CLS_INF;
    end else if (x_zero || y_zero) begin
      r.cls = CLS_ZERO;
    end else begin
      r.cls = CLS_NORM;
    end
    return r;
  endfunction

  // Normalise by one bit, round to nearest even, then saturate the exponent:
  // overflow (also from a rounding carry) to infinity, underflow to zero.
  function automatic logic [15:0] round_pack(input mul_raw_t r);
    logic [15:0]       res;
    logic [6:0]        kept;
    logic              grd, stk, up;
    logic [7:0]        m8;
    logic signed [9:0] e;
    res = {r.sgn, 15'h0000};
    if (r.mant[15]) begin
      kept = r.mant[14:8];
      grd  = r.mant[7];
      stk  = |r.mant[6:0];
      e    = r.exp + 10'sd1;
    end else begin
      kept = r.mant[13:7];
      grd  = r.mant[6];
      stk  = |r.mant[5:0];
      e    = r.exp;
    end
    up = grd & (stk | kept[0]);
    m8 = {1'b0, kept} + 8'(up);
    // a carry out of the fraction leaves it zero and bumps the exponent
    e  = e + $signed(10'(m8[7]));
    case (r.cls)
      CLS_NAN:  res = QNAN;
      CLS_INF:  res = {r.sgn, 8'hFF, 7'h00};
      CLS_ZERO: res = {r.sgn, 15'h0000};
      default: begin
        if (e >= 10'sd255) begin
          res = {r.sgn, 8'hFF, 7'h00};
        end else if (e <= 10'sd0) begin
          res = {r.sgn, 15'h0000};
        end else begin
          res = {r.sgn, e[7:0], m8[6:0]};
        end
      end
    endcase
    return res;
  endfunction

  mul_raw_t    raw_c;
  logic [15:0] res_p [RN];

  assign raw_c = mul_unpack(a, b);

  if (MUL_LAT == 1) begin : g_lat1
    // single stage: multiply and round in one cycle
    always_ff @(posedge clk) begin
      if (en) res_p[0] <= round_pack(raw_c);
    end
  end else begin : g_latn
    mul_raw_t raw_p1;
    always_ff @(posedge clk) begin
      if (en) begin
        // stage 1: raw product
        raw_p1   <= raw_c;
        // stage 2: rounded result
        res_p[0] <= round_pack(raw_p1);
        // stages 3..MUL_LAT: retiming delay
        for (int i = 1; i < RN; i++) res_p[i] <= res_p[i-1];
      end
    end
  end

  assign p = res_p[RN-1];

endmodule

// File: rtl/mul_tree_bf16.sv
// Balanced bf16 product tree over NUM_IN lanes with valid/ready handshake.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of mul_tree_bf16_if (operands in, product out)
// Lanes at or above in_cnt are replaced by 1.0. Latency is
// log2(NUM_IN)*MUL_LAT; a stalled output freezes the whole pipeline.
module mul_tree_bf16
  import bf16_pkg::*;
#(
  parameter int NUM_IN  = 8,
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  mul_tree_bf16_if.slave    bus
);

  localparam int LV    = $clog2(NUM_IN);
  localparam int L     = LV * MUL_LAT;
  localparam int CNT_W = $clog2(NUM_IN) + 1;

  // heap-ordered tree: node n = node 2n * node 2n+1, leaves at NUM_IN..2*NUM_IN-1
  logic [15:0]      node  [1:2*NUM_IN-1];
  logic             vld_p [L];
  logic [TAG_W-1:0] tag_p [L];
  logic             en;

  assign en = !(vld_p[L-1] && !bus.out_ready);

  for (genvar k = 0; k < NUM_IN; k++) begin : g_leaf
    // in_cnt above NUM_IN naturally saturates: every lane is then active
    assign node[NUM_IN+k] = (CNT_W'(k) < bus.in_cnt) ? bus.in_ops[16*k +: 16] : ONE;
  end

  for (genvar n = 1; n < NUM_IN; n++) begin : g_node
    bf16_mul_pipe #(.MUL_LAT(MUL_LAT)) u_mul (
      .clk (clk),
      .en  (en),
      .a   (node[2*n]),
      .b   (node[2*n+1]),
      .p   (node[n])
    );
  end

  // valid stages 0..L-1, aligned with the tree data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) vld_p[i] <= 1'b0;
    end else if (en) begin
      vld_p[0] <= bus.in_valid;
      for (int i = 1; i < L; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // tag stages 0..L-1
  always_ff @(posedge clk) begin
    if (en) begin
      tag_p[0] <= bus.in_tag;
      for (int i = 1; i < L; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  // outputs read as zero whenever no result is present
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_p[L-1];
  assign bus.out_prod  = vld_p[L-1] ? node[1] : 16'h0000;
  assign bus.out_tag   = vld_p[L-1] ? tag_p[L-1] : '0;
  assign bus.out_flags = vld_p[L-1] ? flags_of(node[1]) : 3'b000;

endmodule
